// File: rtl/div32_iter.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient}; RISC-V divide-by-zero/overflow semantics.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration when |a| < |b| (results unchanged, latency 2).
module div32_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sign,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] bmag_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [CW-1:0]    cnt_reg;
  logic             a_neg_reg;
  logic             b_neg_reg;
  logic             bzero_reg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             trial_ok;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign a_mag = (sign & a[WIDTH-1]) ? -a : a;
  assign b_mag = (sign & b[WIDTH-1]) ? -b : b;

  // The stored remainder is always < |b|, so only the shifted value needs the extra bit;
  // its MSB after the trial subtract is the borrow.
  assign rem_shift = {rem_reg, dvd_reg[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, bmag_reg};
  assign trial_ok  = ~diff[WIDTH];

  assign q_fix = bzero_reg ? '1 :
                 (a_neg_reg ^ b_neg_reg) ? -q_reg : q_reg;
  assign r_fix = a_neg_reg ? -rem_reg : rem_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      dvd_reg     <= '0;
      bmag_reg    <= '0;
      q_reg       <= '0;
      rem_reg     <= '0;
      cnt_reg     <= '0;
      a_neg_reg   <= 1'b0;
      b_neg_reg   <= 1'b0;
      bzero_reg   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            a_neg_reg <= sign & a[WIDTH-1];
            b_neg_reg <= sign & b[WIDTH-1];
            bzero_reg <= (b == '0);
            dvd_reg   <= a_mag;
            bmag_reg  <= b_mag;
            q_reg     <= '0;
            rem_reg   <= '0;
            cnt_reg   <= CNT_LOAD;
            if (b == '0) begin
              // remainder magnitude re-signed in FIX reproduces a exactly
              rem_reg   <= a_mag;
              state_reg <= FIX;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (a_mag < b_mag) begin
              rem_reg   <= a_mag;
              state_reg <= FIX;
            end
`endif
            else begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          rem_reg <= trial_ok ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          q_reg   <= {q_reg[WIDTH-2:0], trial_ok};
          dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg == '0) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          result      <= {r_fix, q_fix};
          div_by_zero <= bzero_reg;
          done        <= 1'b1;
          state_reg   <= DONE;
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div32_iter.sv
// Randomized bench for div32_iter against an arithmetic reference; honours DIV_EARLY_OUT_EN for latency.
module tb_div32_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sign;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  // expected-behaviour state shared by driver and compare process
  bit          chk_en = 0;
  bit          pending = 0;
  int          st = 0;
  int          due = 0;
  logic [63:0] exp_res = '0;
  bit          exp_dbz = 0;
  logic [63:0] held_res = '0;
  bit          held_dbz = 0;

  logic [63:0] cmp_res;
  bit          cmp_dbz;
  bit          cmp_done;
  bit          cmp_busy;

  div32_iter #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .sign(sign),
    .busy(busy),
    .done(done),
    .result(result),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_cnt, act, expv);
    end
  endtask

  // Reference: RISC-V division done with 64-bit arithmetic
  function automatic void model(input logic [31:0] op_a, input logic [31:0] op_b, input logic op_s,
                                output logic [63:0] r, output bit dbz, output int lat);
    longint xa, xb, q, rm, ma, mb;
    if (op_s) begin
      xa = longint'($signed(op_a));
      xb = longint'($signed(op_b));
    end else begin
      xa = longint'({32'b0, op_a});
      xb = longint'({32'b0, op_b});
    end
    ma = (xa < 0) ? -xa : xa;
    mb = (xb < 0) ? -xb : xb;
    if (op_b == 32'd0) begin
      r   = {op_a, 32'hFFFF_FFFF};
      dbz = 1'b1;
      lat = 2;
    end else begin
      q   = xa / xb;
      rm  = xa % xb;
      r   = {rm[31:0], q[31:0]};
      dbz = 1'b0;
      lat = 34;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) lat = 2;
`endif
    end
  endfunction

  // Issue one operation (caller is just after a posedge); optionally poke start while busy and in DONE.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input bit poke);
    logic [63:0] r;
    bit d;
    int lat;
    model(ta, tb, ts, r, d, lat);
    a = ta; b = tb; sign = ts; start = 1'b1;
    st = edge_cnt; due = edge_cnt + lat; exp_res = r; exp_dbz = d; pending = 1;
    @(posedge clk); #1;
    start = 1'b0;
    while (edge_cnt <= due) begin
      a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
      start = poke && ((edge_cnt - st == 5 && edge_cnt < due) ||
                       (edge_cnt - st == 20 && edge_cnt < due) || edge_cnt == due);
      @(posedge clk); #1;
    end
    start = 1'b0;
    held_res = exp_res; held_dbz = exp_dbz; pending = 0;
    $display("op sign=%0d a=%h b=%h -> result=%h dbz=%0d latency=%0d", ts, ta, tb, result, div_by_zero, lat);
  endtask

  // Per-cycle comparison against the expected-behaviour state
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_done = pending && (edge_cnt == due);
      cmp_busy = pending && (edge_cnt > st) && (edge_cnt <= due);
      cmp_res  = (pending && edge_cnt >= due) ? exp_res : held_res;
      cmp_dbz  = (pending && edge_cnt >= due) ? exp_dbz : held_dbz;
      chk("done", 64'(done), 64'(cmp_done));
      chk("busy", 64'(busy), 64'(cmp_busy));
      chk("result", result, cmp_res);
      chk("div_by_zero", 64'(div_by_zero), 64'(cmp_dbz));
    end
  end

  initial begin
    logic [31:0] ra, rb;
    int lat_pin;
    logic [63:0] mr;
    bit md;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; sign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_result", result, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk_en = 1;

    // model pins
    model(32'd100, 32'd7, 1'b0, mr, md, lat_pin);
    chk("model_t1", mr, {32'd2, 32'd14});
    chk("model_t1_lat", 64'(lat_pin), 64'd34);
    model(32'hFFFF_FF9C, 32'd7, 1'b1, mr, md, lat_pin);
    chk("model_t2", mr, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mr, md, lat_pin);
    chk("model_ovf", mr, {32'd0, 32'h8000_0000});

    run_op(32'd100, 32'd7, 1'b0, 0);
    chk("t1_result", result, {32'd2, 32'd14});
    chk("t1_dbz", 64'(div_by_zero), 64'd0);

    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 0);
    chk("t2a_result", result, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 0);
    chk("t2b_result", result, {32'h0000_0002, 32'hFFFF_FFF2});

    run_op(32'h1234_5678, 32'd0, 1'b0, 0);
    chk("t3u_result", result, {32'h1234_5678, 32'hFFFF_FFFF});
    chk("t3u_dbz", 64'(div_by_zero), 64'd1);
    run_op(32'h1234_5678, 32'd0, 1'b1, 0);
    chk("t3s_result", result, {32'h1234_5678, 32'hFFFF_FFFF});

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    chk("t4s_result", result, {32'd0, 32'h8000_0000});
    chk("t4s_dbz", 64'(div_by_zero), 64'd0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    chk("t4u_result", result, {32'h8000_0000, 32'd0});

    // ignored starts while busy and in DONE
    run_op(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 1);
    chk("t5_result", result, {32'(32'hDEAD_BEEF % 32'h1234), 32'(32'hDEAD_BEEF / 32'h1234)});

    // reset in the middle of an operation
    model(32'h7654_3210, 32'd3, 1'b0, mr, md, lat_pin);
    a = 32'h7654_3210; b = 32'd3; sign = 1'b0; start = 1'b1;
    st = edge_cnt; due = edge_cnt + lat_pin; exp_res = mr; exp_dbz = md; pending = 1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; pending = 0; held_res = '0; held_dbz = 0;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_result", result, 64'd0);
    repeat (40) begin @(posedge clk); #1; end
    $display("op reset mid-operation -> result=%h busy=%0d", result, busy);

    run_op(32'd3, 32'd10, 1'b0, 0);
    chk("t6_result", result, {32'd3, 32'd0});

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = 32'($urandom_range(1, 255)); end
        2: begin ra = $urandom; rb = 32'd0; end
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(51, 1000)); end
        default: begin ra = $urandom; rb = -32'($urandom_range(1, 40)); end
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
